// File: rtl/fp_det_pkg.sv
// fp_det_pkg: constants and helpers shared by the determinant
// accelerator and its Avalon matrix store.
package fp_det_pkg;

    localparam int AVALON_ADDR_W = 24;
    localparam int DATA_W        = 32;
    localparam int MAX_DIMENSION = 32;

    localparam logic [DATA_W-1:0] NaN       = 32'h7FC00000;
    localparam logic [DATA_W-1:0] FLOAT_ONE = 32'h3F800000;

    typedef logic [DATA_W-1:0]        word_t;
    typedef logic [AVALON_ADDR_W-1:0] addr_t;

    function automatic logic [AVALON_ADDR_W-3:0] word_index(
        input addr_t a,
        input addr_t base
    );
        return (AVALON_ADDR_W-2)'((a - base) >> 2);
    endfunction

endpackage

// File: rtl/fp_slave_bram.sv
// fp_slave_bram: simple dual-port word RAM, byte-enable write port,
// registered read port. Contents are not reset.
module fp_slave_bram
    import fp_det_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [3:0]        be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fp_matrix_slave.sv
// fp_matrix_slave: Avalon-MM pipelined slave holding one matrix.
// Optional FP_SLAVE_THROTTLE_EN adds LFSR-driven waitrequest stalls.
module fp_matrix_slave
    import fp_det_pkg::*;
#(
    parameter logic [AVALON_ADDR_W-1:0] BASE_ADDR    = 24'h000000,
    parameter int                       DEPTH        = 1024,
    parameter int                       READ_LATENCY = 2,
    parameter int                       MAX_PENDING  = 4,
    parameter logic [DATA_W-1:0]        NaN          = fp_det_pkg::NaN
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [AVALON_ADDR_W-1:0] address,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    input  logic [3:0]               byteenable,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    output logic                     waitrequest,
    output logic [2:0]               pending,
    output logic                     err,
    input  logic                     clr_err
);

    localparam int L  = READ_LATENCY;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AVALON_ADDR_W-3:0] DEPTH_W =
        (AVALON_ADDR_W-2)'(DEPTH);
    localparam logic [2:0] MAXP = 3'(MAX_PENDING);

    logic                     init_q, init_d;
    logic [2:0]               pend_q, pend_d;
    logic                     err_q, err_d;
    logic [L-1:0]             vld_q, vld_d;
    logic [L-1:0]             oob_q, oob_d;
    logic [DATA_W-1:0]        hold_q, hold_d;
    logic [AVALON_ADDR_W-3:0] idx;
    logic                     oob, rd_acc, wr_acc, rw_err, throttle;
    logic [DATA_W-1:0]        ram_rdata, tail_data;

    assign idx    = word_index(address, BASE_ADDR);
    assign oob    = idx >= DEPTH_W;
    assign wr_acc = write & ~waitrequest;
    assign rd_acc = read & ~write & ~waitrequest;
    assign rw_err = read & write & ~waitrequest;

    assign waitrequest   = init_q | (pend_q == MAXP) | throttle;
    assign readdatavalid = vld_q[L-1];
    assign readdata      = readdatavalid
                         ? (oob_q[L-1] ? NaN : tail_data)
                         : hold_q;
    assign pending = pend_q;
    assign err     = err_q;

    fp_slave_bram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~oob),
        .waddr (idx[AW-1:0]),
        .be    (byteenable),
        .wdata (writedata),
        .re    (rd_acc & ~oob),
        .raddr (idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    // RAM output register is stage 1; the rest of the latency lives here
    generate
        if (L == 1) begin : g_lat1
            assign tail_data = ram_rdata;
        end else begin : g_latn
            logic [DATA_W-1:0] dsh_q [L-1];
            logic [DATA_W-1:0] dsh_d [L-1];
            always_comb begin
                dsh_d[0] = ram_rdata;
                for (int i = 1; i < L-1; i++) dsh_d[i] = dsh_q[i-1];
            end
            always_ff @(posedge clk) begin
                dsh_q <= dsh_d;
            end
            assign tail_data = dsh_q[L-2];
        end
    endgenerate

`ifdef FP_SLAVE_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
    assign throttle = (lfsr_q[1:0] == 2'b00);
`else
    assign throttle = 1'b0;
`endif

    always_comb begin
        init_d   = 1'b0;
        vld_d    = vld_q << 1;
        vld_d[0] = rd_acc;
        oob_d    = oob_q << 1;
        oob_d[0] = oob;
        pend_d   = pend_q + {2'b00, rd_acc} - {2'b00, readdatavalid};
        hold_d   = readdata;
        err_d    = err_q;
        if (clr_err) err_d = 1'b0;
        // a new error in the same cycle outranks the clear
        if (rw_err | ((wr_acc | rd_acc) & oob)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q <= 1'b1;
            pend_q <= '0;
            err_q  <= 1'b0;
            vld_q  <= '0;
            oob_q  <= '0;
            hold_q <= '0;
        end else begin
            init_q <= init_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
            oob_q  <= oob_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: tb/tb_fp_matrix_slave.sv
// tb_fp_matrix_slave: directed checks of fp_matrix_slave, default
// instance plus a READ_LATENCY=4 / MAX_PENDING=2 instance.
module tb_fp_matrix_slave;

    localparam logic [23:0] BASE = 24'h010000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] address = '0;
    logic        read = 1'b0, write = 1'b0, clr_err = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = 4'hF;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest, err;
    logic [2:0]  pending;

    logic [23:0] l_address = '0;
    logic        l_read = 1'b0, l_write = 1'b0;
    logic [31:0] l_writedata = '0;
    logic [31:0] l_readdata;
    logic        l_readdatavalid, l_waitrequest, l_err;
    logic [2:0]  l_pending;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    fp_matrix_slave #(.BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .pending(pending), .err(err), .clr_err(clr_err)
    );

    fp_matrix_slave #(
        .BASE_ADDR(BASE), .READ_LATENCY(4), .MAX_PENDING(2)
    ) u_lim (
        .clk(clk), .reset_n(reset_n), .address(l_address),
        .read(l_read), .write(l_write), .writedata(l_writedata),
        .byteenable(4'hF), .readdata(l_readdata),
        .readdatavalid(l_readdatavalid), .waitrequest(l_waitrequest),
        .pending(l_pending), .err(l_err), .clr_err(1'b0)
    );

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr_word(input bit lim, input int idx,
                           input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        if (lim) begin
            l_address = BASE + 24'(4 * idx);
            l_writedata = d;
            l_write = 1'b1;
            while (l_waitrequest && n < 20) begin tick(); n++; end
        end else begin
            address = BASE + 24'(4 * idx);
            writedata = d;
            byteenable = be;
            write = 1'b1;
            while (waitrequest && n < 20) begin tick(); n++; end
        end
        if (n >= 20) begin
            vectors++; miscompares++;
            $display("FAIL wr_accept idx %0d never accepted", idx);
        end
        tick();
        write = 1'b0;
        l_write = 1'b0;
        byteenable = 4'hF;
    endtask

    task automatic rd_word(input int idx, output logic [31:0] d,
                           output int lat);
        int c0 = cyc;
        int n = 0;
        address = BASE + 24'(4 * idx);
        read = 1'b1;
        tick();
        read = 1'b0;
        while (!readdatavalid && n < 10) begin tick(); n++; end
        d = readdata;
        lat = readdatavalid ? cyc - c0 : -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        vectors += 6;
        if (waitrequest !== 1'b1) begin miscompares++;
            $display("FAIL rst_wait got %b want 1", waitrequest); end
        if (readdatavalid !== 1'b0) begin miscompares++;
            $display("FAIL rst_valid got %b want 0", readdatavalid); end
        if (pending !== 3'd0) begin miscompares++;
            $display("FAIL rst_pending got %0d want 0", pending); end
        if (err !== 1'b0) begin miscompares++;
            $display("FAIL rst_err got %b want 0", err); end
        if (readdata !== 32'h0) begin miscompares++;
            $display("FAIL rst_data got %h want 0", readdata); end
        if (l_waitrequest !== 1'b1) begin miscompares++;
            $display("FAIL rst_lwait got %b want 1", l_waitrequest); end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (waitrequest !== 1'b1) begin miscompares++;
            $display("FAIL rel_wait_pre got %b want 1", waitrequest); end
        tick();
        vectors += 2;
        if (waitrequest !== 1'b0) begin miscompares++;
            $display("FAIL rel_wait got %b want 0", waitrequest); end
        if (l_waitrequest !== 1'b0) begin miscompares++;
            $display("FAIL rel_lwait got %b want 0", l_waitrequest); end
    endtask

    task automatic test_write_burst();
        int sent = 0, got = 0, first = -1, last = -1, c;
        int exp_c[$];
        logic [31:0] exp_d[$], e;
        for (int n = 0; n < 9; n++)
            wr_word(0, n, 32'h3F800000 + 32'(n), 4'hF);
        for (int k = 0; k < 60 && got < 9; k++) begin
            if (sent < 9) begin
                address = BASE + 24'(4 * sent);
                read = 1'b1;
            end else read = 1'b0;
            if (read && !waitrequest) begin
                exp_c.push_back(cyc + 2);
                exp_d.push_back(32'h3F800000 + 32'(sent));
                sent++;
            end
            tick();
            if (readdatavalid) begin
                vectors++;
                if (first < 0) first = cyc;
                last = cyc;
                if (exp_d.size() == 0) begin miscompares++;
                    $display("FAIL burst_extra got %h want none", readdata);
                end else begin
                    e = exp_d.pop_front();
                    c = exp_c.pop_front();
                    if (readdata !== e || cyc !== c) begin miscompares++;
                        $display("FAIL burst_rd got %h @%0d want %h @%0d",
                                 readdata, cyc, e, c);
                    end
                end
                got++;
            end
        end
        read = 1'b0;
        vectors += 2;
        if (got !== 9) begin miscompares++;
            $display("FAIL burst_count got %0d want 9", got); end
        if (last - first !== 8) begin miscompares++;
            $display("FAIL burst_b2b got span %0d want 8", last - first); end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        int lat;
        wr_word(0, 5, 32'hFFFFFFFF, 4'hF);
        wr_word(0, 5, 32'h00000000, 4'b0101);
        rd_word(5, d, lat);
        vectors += 2;
        if (d !== 32'hFF00FF00) begin miscompares++;
            $display("FAIL be_data got %h want ff00ff00", d); end
        if (lat !== 2) begin miscompares++;
            $display("FAIL be_latency got %0d want 2", lat); end
        tick();
        vectors++;
        if (readdatavalid !== 1'b0 || readdata !== 32'hFF00FF00) begin
            miscompares++;
            $display("FAIL hold got v=%b %h want v=0 ff00ff00",
                     readdatavalid, readdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        int lat, nv = 0;
        rd_word(1024, d, lat);
        vectors += 3;
        if (d !== 32'h7FC00000) begin miscompares++;
            $display("FAIL oob_data got %h want 7fc00000", d); end
        if (lat !== 2) begin miscompares++;
            $display("FAIL oob_latency got %0d want 2", lat); end
        if (err !== 1'b1) begin miscompares++;
            $display("FAIL oob_err got %b want 1", err); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        vectors++;
        if (err !== 1'b0) begin miscompares++;
            $display("FAIL clr_err got %b want 0", err); end
        wr_word(0, 1023, 32'h12345678, 4'hF);
        rd_word(1023, d, lat);
        vectors += 2;
        if (d !== 32'h12345678) begin miscompares++;
            $display("FAIL last_word got %h want 12345678", d); end
        if (err !== 1'b0) begin miscompares++;
            $display("FAIL last_err got %b want 0", err); end
        wr_word(0, 1024, 32'hBAADF00D, 4'hF);
        vectors++;
        if (err !== 1'b1) begin miscompares++;
            $display("FAIL oob_wr_err got %b want 1", err); end
        rd_word(0, d, lat);
        vectors++;
        if (d !== 32'h3F800000) begin miscompares++;
            $display("FAIL oob_wr_alias got %h want 3f800000", d); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        address = BASE + 24'(4 * 2000);
        read = 1'b1; clr_err = 1'b1;
        tick();
        read = 1'b0; clr_err = 1'b0;
        vectors++;
        if (err !== 1'b1) begin miscompares++;
            $display("FAIL set_wins got %b want 1", err); end
        repeat (3) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        address = BASE + 24'(4 * 7);
        writedata = 32'hDEADBEEF;
        read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (readdatavalid) nv++;
            tick();
        end
        vectors += 2;
        if (err !== 1'b1) begin miscompares++;
            $display("FAIL rw_err got %b want 1", err); end
        if (nv !== 0) begin miscompares++;
            $display("FAIL rw_noread got %0d responses want 0", nv); end
        rd_word(7, d, lat);
        vectors++;
        if (d !== 32'hDEADBEEF) begin miscompares++;
            $display("FAIL rw_write got %h want deadbeef", d); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic test_pending_limit();
        int sent = 0, got = 0, maxp = 0, c;
        int exp_c[$];
        logic [31:0] exp_d[$], e;
        for (int n = 0; n < 8; n++)
            wr_word(1, n, 32'hA0000000 + 32'(n), 4'hF);
        for (int k = 0; k < 100 && got < 8; k++) begin
            if (sent < 8) begin
                l_address = BASE + 24'(4 * sent);
                l_read = 1'b1;
            end else l_read = 1'b0;
            if (l_read && !l_waitrequest) begin
                exp_c.push_back(cyc + 4);
                exp_d.push_back(32'hA0000000 + 32'(sent));
                sent++;
            end
            tick();
            vectors++;
            if (l_pending > 3'd2 ||
                (l_pending == 3'd2 && l_waitrequest !== 1'b1)) begin
                miscompares++;
                $display("FAIL lim_pend got pend=%0d wait=%b want <=2, wait=1",
                         l_pending, l_waitrequest);
            end
            if (int'(l_pending) > maxp) maxp = int'(l_pending);
            if (l_readdatavalid) begin
                vectors++;
                if (exp_d.size() == 0) begin miscompares++;
                    $display("FAIL lim_extra got %h want none", l_readdata);
                end else begin
                    e = exp_d.pop_front();
                    c = exp_c.pop_front();
                    if (l_readdata !== e || cyc !== c) begin miscompares++;
                        $display("FAIL lim_rd got %h @%0d want %h @%0d",
                                 l_readdata, cyc, e, c);
                    end
                end
                got++;
            end
        end
        l_read = 1'b0;
        vectors += 2;
        if (got !== 8) begin miscompares++;
            $display("FAIL lim_count got %0d want 8", got); end
        if (maxp !== 2) begin miscompares++;
            $display("FAIL lim_peak got %0d want 2", maxp); end
    endtask

    task automatic test_reset_midburst();
        int nv = 0;
        for (int n = 0; n < 2; n++) begin
            address = BASE + 24'(4 * n);
            read = 1'b1;
            tick();
        end
        read = 1'b0;
        reset_n = 1'b0;
        #1;
        vectors += 2;
        if (readdatavalid !== 1'b0) begin miscompares++;
            $display("FAIL mid_rst_valid got %b want 0", readdatavalid); end
        if (pending !== 3'd0) begin miscompares++;
            $display("FAIL mid_rst_pend got %0d want 0", pending); end
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (readdatavalid) nv++;
        end
        vectors++;
        if (nv !== 0) begin miscompares++;
            $display("FAIL mid_rst_resp got %0d want 0", nv); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_byteenable();
        test_out_of_range();
        test_pending_limit();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
